// File: rtl/alu_issue_pkg.sv
// alu_pkg: opcodes, FSM states, instruction field positions and op legality helpers for alu_issue
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_LI  = 4'd5;
  localparam int OP_HI   = 19;
  localparam int OP_LO   = 16;
  localparam int RD_LO   = 14;
  localparam int RS1_LO  = 12;
  localparam int RS2_LO  = 10;
  localparam int ISEL_B  = 9;
  localparam int IMM_LO  = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_NOT;
  endfunction
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_LI;
  endfunction
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake and write-back report bundle
interface alu_issue_if #(parameter int W = 8);
  logic          instr_valid;
  logic          instr_ready;
  logic [19:0]   instr_data;
  logic          res_valid;
  logic [1:0]    res_rd;
  logic [W-1:0]  res_data;
  modport master (output instr_valid, instr_data, input instr_ready, res_valid, res_rd, res_data);
  modport slave  (input instr_valid, instr_data, output instr_ready, res_valid, res_rd, res_data);
endinterface

// File: rtl/alu_issue_regfile.sv
// alu_regfile: NREG x W register file, two operand reads, debug read, one synchronous write
module alu_regfile #(parameter int NREG = 4, parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [1:0]   wa,
  input  logic [W-1:0] wd,
  input  logic [1:0]   ra,
  input  logic [1:0]   rb,
  input  logic [1:0]   dsel,
  output logic [W-1:0] a_data,
  output logic [W-1:0] b_data,
  output logic [W-1:0] d_data
);
  logic [W-1:0] rf [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (we)
      rf[wa] <= wd;
  assign a_data = rf[ra];
  assign b_data = rf[rb];
  assign d_data = rf[dsel];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: issues packed instructions to an external combinational ALU and writes results back.
// Define ALU_ISSUE_FLAGS_EN to add the flag_z/flag_n result flags.
module alu_issue import alu_pkg::*; #(parameter int NREG = 4, parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_if.slave   bus,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_mode,
  input  logic [W-1:0] alu_s,
  output logic         err,
  input  logic [1:0]   dbg_sel,
  output logic [W-1:0] dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic         flag_z,
  output logic         flag_n
`endif
);
  state_t state, next;
  logic [3:0] op;
  logic [1:0] rd, rs1, rs2, rd_q, wa;
  logic [7:0] imm;
  logic isel, accept, we;
  logic [W-1:0] wd, a_data, b_data;
  assign op   = bus.instr_data[OP_HI:OP_LO];
  assign rd   = bus.instr_data[RD_LO+1:RD_LO];
  assign rs1  = bus.instr_data[RS1_LO+1:RS1_LO];
  assign rs2  = bus.instr_data[RS2_LO+1:RS2_LO];
  assign isel = bus.instr_data[ISEL_B];
  assign imm  = bus.instr_data[IMM_LO+7:IMM_LO];
  assign bus.instr_ready = state == IDLE;
  assign bus.res_valid   = state == WB;
  alu_regfile #(.NREG(NREG), .W(W)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(rs1), .rb(rs2), .dsel(dbg_sel),
    .a_data(a_data), .b_data(b_data), .d_data(dbg_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // both LI and the ISSUE result land in the rf on the edge that enters WB
  always_comb begin
    accept = bus.instr_valid && state == IDLE;
    next   = state == ISSUE ? WB :
             state == WB ? IDLE :
             !accept ? IDLE :
             is_alu_op(op) ? ISSUE :
             op == OP_LI ? WB : IDLE;
    we = state == ISSUE || (accept && op == OP_LI);
    wa = state == ISSUE ? rd_q : rd;
    wd = state == ISSUE ? alu_s : W'(imm);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_mode <= '0;
      rd_q     <= '0;
      bus.res_rd   <= '0;
      bus.res_data <= '0;
      err      <= 1'b0;
    end else begin
      if (accept && is_alu_op(op)) begin
        alu_a    <= a_data;
        alu_b    <= isel ? W'(imm) : b_data;
        alu_mode <= op;
        rd_q     <= rd;
      end
      if (we) begin
        bus.res_rd   <= wa;
        bus.res_data <= wd;
      end
      if (accept && !is_legal(op)) err <= 1'b1;
    end
`ifdef ALU_ISSUE_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (we) begin
      flag_z <= wd == '0;
      flag_n <= wd[W-1];
    end
`endif
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural ALU attached
module tb_alu_issue;
  logic clk = 0, rst_n = 0;
  logic [7:0] alu_a, alu_b, alu_s, dbg_data;
  logic [3:0] alu_mode;
  logic [1:0] dbg_sel = 0;
  logic err;
`ifdef ALU_ISSUE_FLAGS_EN
  logic flag_z, flag_n;
`endif
  int pass_cnt = 0, tot_cnt = 0;
  logic [9:0] exp_q[$];
  logic [7:0] m [4];
  alu_issue_if #(.W(8)) bus();
  alu_issue #(.NREG(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_s(alu_s),
    .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );
  always #5 clk = ~clk;
  assign alu_s = alu_mode == 0 ? alu_a + alu_b :
                 alu_mode == 1 ? alu_a - alu_b :
                 alu_mode == 2 ? alu_a & alu_b :
                 alu_mode == 3 ? alu_a | alu_b :
                 alu_mode == 4 ? ~alu_a : 8'h00;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [7:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return ~a;
      default: return b;
    endcase
  endfunction
  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic isel, input logic [7:0] imm,
                      input bit hold = 0, input bit track = 1);
    int n = 0;
    logic [7:0] v;
    @(negedge clk);
    bus.instr_valid = 1;
    bus.instr_data = {op, rd, rs1, rs2, isel, 1'b0, imm};
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("ready_timeout", 0, 1);
    if (track && op <= 5) begin
      v = op == 5 ? imm : model(op, m[rs1], isel ? imm : m[rs2]);
      exp_q.push_back({rd, v});
      m[rd] = v;
    end
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 0;
  endtask
  task automatic dbg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    check(tag, dbg_data, exp);
  endtask
  always @(negedge clk) if (rst_n && bus.res_valid) begin
    if (exp_q.size() == 0) check("spurious_res_valid", 1, 0);
    else begin
      logic [9:0] e;
      e = exp_q.pop_front();
      check("res_rd", bus.res_rd, e[9:8]);
      check("res_data", bus.res_data, e[7:0]);
    end
  end
  initial begin
    int n;
    bus.instr_valid = 0;
    bus.instr_data = '0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.instr_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_err", err, 0);
    rst_n = 1;
    send(5, 1, 0, 0, 0, 8'h05);
    @(negedge clk);
    dbg("li_dbg_r1", 1, 8'h05);
    send(5, 2, 0, 0, 0, 8'h03);
    send(0, 0, 1, 2, 0, 8'h00);
    @(negedge clk);
    check("issue_mode", alu_mode, 0);
    check("issue_a", alu_a, 8'h05);
    check("issue_b", alu_b, 8'h03);
    check("issue_ready", bus.instr_ready, 0);
    @(negedge clk);
    check("wb_valid", bus.res_valid, 1);
    @(negedge clk);
    check("ready_n3", bus.instr_ready, 1);
    send(1, 3, 2, 1, 0, 8'h00);
`ifdef ALU_ISSUE_FLAGS_EN
    repeat (2) @(negedge clk);
    check("flag_z", flag_z, 0);
    check("flag_n", flag_n, 1);
`endif
    send(5, 2, 0, 0, 0, 8'hFF);
    send(0, 2, 2, 0, 1, 8'h02);
    send(2, 1, 1, 0, 1, 8'h0F);
    send(3, 1, 1, 0, 1, 8'hF0);
    send(4, 0, 0, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    dbg("not_dbg_r0", 0, 8'hF7);
    send(7, 0, 1, 2, 0, 8'h00);
    @(negedge clk);
    check("illegal_err", err, 1);
    check("illegal_ready", bus.instr_ready, 1);
    dbg("illegal_r0", 0, 8'hF7);
    send(0, 3, 0, 1, 0, 8'h00);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    dbg("after_illegal_r3", 3, 8'hEC);
    send(0, 0, 1, 1, 0, 8'h00, 1);
    @(negedge clk);
    check("hold_issue_ready", bus.instr_ready, 0);
    @(negedge clk);
    @(negedge clk);
    check("hold_ready_back", bus.instr_ready, 1);
    bus.instr_valid = 0;
    @(negedge clk);
    check("hold_no_reaccept", bus.instr_ready, 1);
    send(0, 0, 1, 2, 0, 8'h00, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    for (int i = 0; i < 4; i++) m[i] = 0;
    check("mid_rst_a", alu_a, 0);
    check("mid_rst_b", alu_b, 0);
    check("mid_rst_mode", alu_mode, 0);
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_rd", bus.res_rd, 0);
    check("mid_rst_data", bus.res_data, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_ready", bus.instr_ready, 1);
    dbg("mid_rst_r1", 1, 8'h00);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    send(5, 0, 0, 0, 0, 8'h0A);
    send(0, 1, 0, 0, 1, 8'h01);
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin @(negedge clk); n++; end
    check("drain", exp_q.size(), 0);
    dbg("final_r1", 1, 8'h0B);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
